// File: rtl/lcd_byte_sequencer.sv
// lcd_byte_sequencer: arbitrates two byte requesters and plays each byte to
// a 4-bit character LCD as two enable-strobed nibbles, then a settle wait.
// Ports: Clock, Reset (sync, active-high); requester A/B: iReq, iRs, iData,
// oAck (one-cycle grant, asserted in IDLE); oBusy; LCD pins oLCD_*.
// Build option: define LCD_ROUND_ROBIN_EN for alternating grants on
// simultaneous requests; otherwise A has fixed priority.
module lcd_byte_sequencer #(
  parameter int P_SETUP     = 2,
  parameter int P_ENABLE    = 12,
  parameter int P_GAP       = 50,
  parameter int P_WAIT      = 2000,
  parameter int P_LONG_WAIT = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iReqA,
  input  logic       iRsA,
  input  logic [7:0] iDataA,
  output logic       oAckA,
  input  logic       iReqB,
  input  logic       iRsB,
  input  logic [7:0] iDataB,
  output logic       oAckB,
  output logic       oBusy,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_StrataFlashControl,
  output logic       oLCD_ReadWrite,
  output logic [3:0] oLCD_Data
);

  typedef enum logic [3:0] {
    S_IDLE, S_HI_SETUP, S_HI_EN, S_HI_HOLD, S_GAP,
    S_LO_SETUP, S_LO_EN, S_LO_HOLD, S_WAIT
  } state_t;

  // Counter holds remaining cycles minus one in the current state.
  localparam logic [16:0] C_SETUP = 17'(P_SETUP - 1);
  localparam logic [16:0] C_EN    = 17'(P_ENABLE - 1);
  localparam logic [16:0] C_GAP   = 17'(P_GAP - 1);
  localparam logic [16:0] C_WAIT  = 17'(P_WAIT - 1);
  localparam logic [16:0] C_LWAIT = 17'(P_LONG_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [16:0] r_cnt;
  logic [16:0] w_cnt_nxt;
  logic        r_rs;
  logic [7:0]  r_byte;
  logic        w_idle;
  logic        w_grant;
  logic        w_pick_b;
  logic        w_done;
  logic        w_long;

`ifdef LCD_ROUND_ROBIN_EN
  logic r_prio_b;
  assign w_pick_b = iReqB & (~iReqA | r_prio_b);
`else
  assign w_pick_b = iReqB & ~iReqA;
`endif

  assign w_idle  = (r_state == S_IDLE);
  assign w_grant = w_idle & (iReqA | iReqB);
  assign w_done  = (r_cnt == 17'd0);
  // Clear display / return home need the long settle time.
  assign w_long  = ~r_rs & (r_byte[7:2] == 6'd0) & (r_byte != 8'd0);

  assign oAckA = w_grant & ~w_pick_b & ~Reset;
  assign oAckB = w_grant & w_pick_b & ~Reset;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_done ? 17'd0 : r_cnt - 17'd1;
    unique case (r_state)
      S_IDLE: if (w_grant) begin
        w_state_nxt = S_HI_SETUP;
        w_cnt_nxt   = C_SETUP;
      end
      S_HI_SETUP: if (w_done) begin
        w_state_nxt = S_HI_EN;
        w_cnt_nxt   = C_EN;
      end
      S_HI_EN: if (w_done) begin
        w_state_nxt = S_HI_HOLD;
        w_cnt_nxt   = 17'd0;
      end
      S_HI_HOLD: if (w_done) begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = C_GAP;
      end
      S_GAP: if (w_done) begin
        w_state_nxt = S_LO_SETUP;
        w_cnt_nxt   = C_SETUP;
      end
      S_LO_SETUP: if (w_done) begin
        w_state_nxt = S_LO_EN;
        w_cnt_nxt   = C_EN;
      end
      S_LO_EN: if (w_done) begin
        w_state_nxt = S_LO_HOLD;
        w_cnt_nxt   = 17'd0;
      end
      S_LO_HOLD: if (w_done) begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = w_long ? C_LWAIT : C_WAIT;
      end
      S_WAIT: if (w_done) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 17'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 17'd0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 17'd0;
      r_rs    <= 1'b0;
      r_byte  <= 8'd0;
`ifdef LCD_ROUND_ROBIN_EN
      r_prio_b <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_rs   <= w_pick_b ? iRsB : iRsA;
        r_byte <= w_pick_b ? iDataB : iDataA;
`ifdef LCD_ROUND_ROBIN_EN
        r_prio_b <= ~w_pick_b;
`endif
      end
    end
  end

  // LCD pins decode from state so reset silences them on its edge.
  always_comb begin
    oBusy               = ~w_idle;
    oLCD_Enabled        = (r_state == S_HI_EN) | (r_state == S_LO_EN);
    oLCD_RegisterSelect = ~w_idle & r_rs;
    oLCD_Data           = 4'd0;
    unique case (r_state)
      S_HI_SETUP, S_HI_EN, S_HI_HOLD, S_GAP:
        oLCD_Data = r_byte[7:4];
      S_LO_SETUP, S_LO_EN, S_LO_HOLD, S_WAIT:
        oLCD_Data = r_byte[3:0];
      default:
        oLCD_Data = 4'd0;
    endcase
  end

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// tb_lcd_byte_sequencer: randomized and directed bench for
// lcd_byte_sequencer against a segment-table timing model.
module tb_lcd_byte_sequencer;

  localparam int S  = 2;
  localparam int E  = 4;
  localparam int G  = 5;
  localparam int W  = 20;
  localparam int LW = 60;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iReqA, iRsA, iReqB, iRsB;
  logic [7:0] iDataA, iDataB;
  logic       oAckA, oAckB, oBusy;
  logic       oLCD_Enabled, oLCD_RegisterSelect;
  logic       oLCD_StrataFlashControl, oLCD_ReadWrite;
  logic [3:0] oLCD_Data;

  int checks = 0;
  int errors = 0;

  lcd_byte_sequencer #(
    .P_SETUP(S), .P_ENABLE(E), .P_GAP(G),
    .P_WAIT(W), .P_LONG_WAIT(LW)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .iReqA(iReqA), .iRsA(iRsA), .iDataA(iDataA), .oAckA(oAckA),
    .iReqB(iReqB), .iRsB(iRsB), .iDataB(iDataB), .oAckB(oAckB),
    .oBusy(oBusy),
    .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    checks++;
    if (oLCD_ReadWrite !== 1'b0 || oLCD_StrataFlashControl !== 1'b1) begin
      errors++;
      $display("FAIL const_pins rw=%b sf=%b exp rw=0 sf=1",
               oLCD_ReadWrite, oLCD_StrataFlashControl);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int wait_len(bit rs, logic [7:0] d);
    return (!rs && d > 0 && d < 4) ? LW : W;
  endfunction

  function automatic int txn_len(bit rs, logic [7:0] d);
    return 2 * S + 2 * E + 2 + G + wait_len(rs, d);
  endfunction

  // {busy, en, rs, data} at cycle k after the grant edge.
  function automatic logic [6:0] model(int k, bit rs, logic [7:0] d);
    int len[8];
    int base;
    logic [3:0] nib;
    len = '{S, E, 1, G, S, E, 1, wait_len(rs, d)};
    base = 0;
    for (int i = 0; i < 8; i++) begin
      if (k < base + len[i]) begin
        nib = (i < 4) ? d[7:4] : d[3:0];
        return {1'b1, (i == 1 || i == 5), rs, nib};
      end
      base += len[i];
    end
    return 7'd0;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (oBusy && t < 500) begin
      @(posedge Clock); #2;
      t++;
    end
    checks++;
    if (oBusy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b exp 0", oBusy);
    end
  endtask

  task automatic run_txn(bit b, bit rs, logic [7:0] d);
    int n;
    logic [8:0] got, exp;
    n = txn_len(rs, d);
    @(posedge Clock); #1;
    if (b) begin iReqB = 1; iRsB = rs; iDataB = d; end
    else   begin iReqA = 1; iRsA = rs; iDataA = d; end
    #1;
    checks++;
    if ({oAckA, oAckB} !== (b ? 2'b01 : 2'b10)) begin
      errors++;
      $display("FAIL grant ack=%b%b exp %b", oAckA, oAckB,
               b ? 2'b01 : 2'b10);
    end
    @(posedge Clock); #1;
    iReqA = 0; iReqB = 0;
    iRsA = 1'($urandom); iRsB = 1'($urandom);
    iDataA = 8'($urandom); iDataB = 8'($urandom);
    #1;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin @(posedge Clock); #2; end
      got = {oAckA, oAckB, oBusy, oLCD_Enabled,
             oLCD_RegisterSelect, oLCD_Data};
      exp = {2'b00, model(k, rs, d)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL txn rs=%0d d=%h k=%0d got %b exp %b",
                 rs, d, k, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1; iReqA = 1; iRsA = 1; iDataA = 8'hFF;
    iReqB = 0; iRsB = 0; iDataB = 8'h00;
    repeat (3) @(posedge Clock);
    #2;
    checks++;
    if ({oAckA, oAckB, oBusy, oLCD_Enabled, oLCD_RegisterSelect,
         oLCD_Data, oLCD_ReadWrite, oLCD_StrataFlashControl}
        !== 11'b000_0000_0001) begin
      errors++;
      $display("FAIL reset ack=%b%b busy=%b en=%b rs=%b d=%h",
               oAckA, oAckB, oBusy, oLCD_Enabled,
               oLCD_RegisterSelect, oLCD_Data);
    end
    iReqA = 0; Reset = 0;
  endtask

  task automatic test_directed();
    run_txn(0, 1, 8'h48);
    run_txn(0, 0, 8'h01);
    run_txn(1, 0, 8'h00);
    run_txn(1, 0, 8'h04);
    run_txn(0, 0, 8'h03);
    run_txn(1, 1, 8'h02);
  endtask

  task automatic test_random();
    bit b, rs;
    logic [7:0] d;
    for (int i = 0; i < 10; i++) begin
      b = 1'($urandom); rs = 1'($urandom); d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rs = 0; d = 8'($urandom_range(1, 3));
      end
      run_txn(b, rs, d);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    bit exp_b;
    Reset = 1;
    @(posedge Clock); #1;
    Reset = 0;
    iReqA = 1; iRsA = 1; iDataA = 8'($urandom);
    iReqB = 1; iRsB = 1; iDataB = 8'($urandom);
    #1;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      while (!(oAckA | oAckB) && t < 200) begin
        @(posedge Clock); #2;
        t++;
      end
`ifdef LCD_ROUND_ROBIN_EN
      exp_b = (g % 2 == 1);
`else
      exp_b = 1'b0;
`endif
      checks++;
      if ({oAckA, oAckB} !== (exp_b ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL arb g=%0d ack=%b%b exp %b", g, oAckA, oAckB,
                 exp_b ? 2'b01 : 2'b10);
      end
      @(posedge Clock); #1;
      iDataA = 8'($urandom); iDataB = 8'($urandom);
      if (g == 3) begin iReqA = 0; iReqB = 0; end
      #1;
    end
    wait_idle();
  endtask

  task automatic test_wait_collision();
    int t = 0;
    logic [7:0] db;
    @(posedge Clock); #1;
    iReqA = 1; iRsA = 1; iDataA = 8'($urandom);
    @(posedge Clock); #1;
    iReqA = 0;
    repeat (2 * S + 2 * E + 2 + G + 3) @(posedge Clock);
    #1;
    db = 8'($urandom);
    iReqB = 1; iRsB = 1; iDataB = db;
    #1;
    while (oBusy && t < 200) begin
      checks++;
      if (oAckB !== 1'b0) begin
        errors++;
        $display("FAIL early_ackB t=%0d ack=%b exp 0", t, oAckB);
      end
      @(posedge Clock); #2;
      t++;
    end
    checks++;
    if ({oBusy, oAckB} !== 2'b01) begin
      errors++;
      $display("FAIL idle_ackB busy=%b ack=%b exp busy=0 ack=1",
               oBusy, oAckB);
    end
    @(posedge Clock); #1;
    iReqB = 0; iDataB = 8'($urandom);
    #1;
    checks++;
    if ({oBusy, oLCD_Data} !== {1'b1, db[7:4]}) begin
      errors++;
      $display("FAIL b_hi busy=%b d=%h exp busy=1 d=%h",
               oBusy, oLCD_Data, db[7:4]);
    end
    wait_idle();
  endtask

  task automatic test_drop();
    @(posedge Clock); #1;
    iReqA = 1; iRsA = 0; iDataA = 8'h38;
    @(posedge Clock); #1;
    iReqA = 0;
    repeat (4) @(posedge Clock);
    #1 iReqB = 1; iDataB = 8'h55;
    repeat (3) @(posedge Clock);
    #1 iReqB = 0;
    #1;
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #2;
      checks++;
      if ({oBusy, oAckB, oLCD_Enabled} !== 3'b000) begin
        errors++;
        $display("FAIL drop i=%0d busy=%b ackB=%b en=%b exp 000",
                 i, oBusy, oAckB, oLCD_Enabled);
      end
    end
  endtask

  task automatic test_reset_abort();
    @(posedge Clock); #1;
    iReqA = 1; iRsA = 1; iDataA = 8'hA5;
    @(posedge Clock); #1;
    iReqA = 0;
    repeat (S) @(posedge Clock);
    #1;
    checks++;
    if (oLCD_Enabled !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre en=%b exp 1", oLCD_Enabled);
    end
    Reset = 1;
    @(posedge Clock); #1;
    checks++;
    if ({oLCD_Enabled, oBusy, oLCD_Data, oLCD_RegisterSelect}
        !== 7'd0) begin
      errors++;
      $display("FAIL abort en=%b busy=%b d=%h rs=%b exp all 0",
               oLCD_Enabled, oBusy, oLCD_Data, oLCD_RegisterSelect);
    end
    Reset = 0;
    #1;
    run_txn(1'($urandom), 1, 8'($urandom));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_wait_collision();
    test_drop();
    test_reset_abort();
    repeat (2) @(posedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
